gf2_min_weight_solve: RTL
=========================

# gf2_min_weight_solve

Consumes a GF(2) system already in reduced row-echelon form and returns the minimum-Hamming-weight solution vector, or reports the system unsolvable. It sits downstream of the RREF reducer and accepts the reducer's matrix layout and `rows`/`cols` sizing unchanged. It enumerates every free-variable assignment, one assignment per cycle.

## Interface

**Parameters**
- `MAX_ROWS`, no default: maximum equation count.
- `MAX_COLS`, no default: maximum augmented width (variables + RHS).
- `MAX_FREE`, default 8: maximum free variables enumerated. Larger systems report overflow.
- `MAX_ROWS_W`, `MAX_COLS_W`, default `$clog2(N+1)` (1 if N≤1): count widths.

**Ports**
- `clk` input, 1: clock.
- `rst_n` input, 1: reset, synchronous, active-low.
- `rows` input, `MAX_ROWS_W`: active equations.
- `cols` input, `MAX_COLS_W`: active columns. `nvars = cols-1`.
- `start` input, 1: request. Sampled only in IDLE.
- `RREF` input, `[MAX_COLS-1:0] x MAX_ROWS`: reduced matrix.
  - Variable j is at bit `MAX_COLS-1-j`.
  - RHS is at bit `MAX_COLS-cols`.
  - Lower bits are ignored.
- `ready` output, 1: one-cycle completion pulse.
- `solvable` output, 1: a solution exists and was enumerated.
- `overflow` output, 1: free variable count exceeds `MAX_FREE`.
- `min_weight` output, `MAX_COLS_W`: popcount of the best solution.
- `solution` output, `[MAX_COLS-1:0]`: best assignment, same variable layout. RHS bit and unused bits are 0.

## Operation

- **IDLE**: when `start`=1, capture `RREF`/`rows`/`cols`, clear the pivot/free bookkeeping, and go to SCAN. Otherwise stay.
- **SCAN**: one row per cycle, r = 0..rows-1.
  - Leading one among the variable bits marks pivot column p(r) and records the row as a pivot row.
  - No variable bit set and RHS=1 means inconsistent: set the `inconsistent` flag, go to DONE after this row.
  - No variable bit set and RHS=0: ignore the row.
  - After the last row, go to COLLECT.
- **COLLECT**: one variable per cycle, j = 0..nvars-1.
  - Each non-pivot j is appended to the free list in ascending order and increments F.
  - If F would exceed `MAX_FREE`, set `overflow` and go to DONE after j = nvars-1.
  - Otherwise go to ENUM with mask = 0 and best weight = all-ones.
- **ENUM**: one mask per cycle, mask = 0..2^F-1.
  - Mask bit i assigns free variable `free_list[i]`.
  - Each pivot variable gets RHS(r) XOR parity(row r variable bits AND free assignment).
  - Popcount the result. If strictly less than the best, record weight and vector; ties keep the earlier mask.
  - After mask = 2^F-1, go to DONE. F=0 takes exactly one ENUM cycle.
- **DONE**: register `solvable` = !inconsistent && !overflow, along with `overflow` and the best result. Pulse `ready` and return to IDLE.
  - When inconsistent or overflow, `min_weight` = 0 and `solution` = 0.
- `start` outside IDLE is ignored.
- Outputs hold until the next DONE.
- `rows` = 0 is legal: SCAN takes zero cycles, and all variables are free.

## Timing

- Reset: state IDLE. `ready`, `solvable`, `overflow`, `min_weight` and `solution` are all 0.
- Reset mid-operation aborts with no `ready` pulse.
- Latency from the `start`-sampling edge to `ready`=1:
  - normal: rows + nvars + 2^F + 2 cycles.
  - inconsistent at row k: k + 3 cycles (COLLECT and ENUM skipped).
  - overflow: rows + nvars + 2 cycles.
- `ready` is high for exactly one cycle. Results are valid in that cycle and held afterwards.
- A new `start` is accepted the cycle after `ready`.
- Popcount and mask counters are sized `MAX_COLS_W` and `MAX_FREE+1` bits, so there is no wrap.

## Structure

- `gf2_pkg` holds:
  - the `solve_state_t` enum (IDLE, SCAN, COLLECT, ENUM, DONE);
  - the width-helper functions shared with the reducer.
- One sub-module, `gf2_leading_one`: combinational priority encoder returning the index and valid bit of the highest set bit within the variable field.

## Test plan

All cases use MAX_ROWS=4, MAX_COLS=5, MAX_FREE=2.

- **One free variable**: rows=2, cols=4, RREF = {5'b10110, 5'b01100}.
  - Expect `ready` 9 cycles after start, `solvable`=1, `min_weight`=1, `solution`=5'b10000.
- **Unique solution**: rows=3, cols=4, RREF = {10010, 01000, 00110}.
  - Expect `ready` at 9 cycles, `min_weight`=2, `solution`=5'b10100.
- **Inconsistent**: rows=2, cols=4, RREF = {10110, 00010}.
  - Expect `ready` at 4 cycles, `solvable`=0, `min_weight`=0, `solution`=0.
- **Overflow**: rows=1, cols=4, RREF = {00000}, giving 3 free variables.
  - Expect `ready` at 6 cycles, `overflow`=1, `solvable`=0.
- **Start while busy, then reset**:
  - `start` re-pulsed during ENUM is ignored; the result equals the first case.
  - `rst_n`=0 during ENUM: no `ready`, all outputs 0, and the next start completes normally.

Source files
------------

// File: rtl/gf2_pkg.sv
// Shared types and width helpers for the GF(2) solver blocks.
// Contents:
//   solve_state_t : controller states of the minimum-weight solver
//   cnt_w(n)      : width of a counter that must hold the value n (min 1)
//   idx_w(n)      : width of an index into n items (min 1)
package gf2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    COLLECT,
    ENUM,
    DONE
  } solve_state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/gf2_leading_one.sv
// Combinational priority encoder: index of the highest set bit of i_vec.
// Ports:
//   i_vec   : input vector (caller masks it down to the variable field)
//   o_idx   : bit index of the most significant one (0 when none)
//   o_valid : at least one bit of i_vec is set
module gf2_leading_one
  import gf2_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned IW = idx_w(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Ascending scan: the last hit, i.e. the highest bit, wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int b = 0; b < int'(W); b++) begin
      if (i_vec[b]) begin
        o_idx   = IW'(b);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf2_min_weight_solve.sv
// Minimum-Hamming-weight solver for a GF(2) system in reduced row-echelon form.
// Scans rows for pivots, collects free variables, then enumerates every free
// assignment (one per cycle) keeping the lightest consistent solution.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   rows, cols : active equations / active augmented columns (nvars = cols-1)
//   start      : request, sampled only while idle
//   RREF       : matrix rows; variable j at bit MAX_COLS-1-j, RHS at MAX_COLS-cols
//   ready      : one-cycle completion pulse
//   solvable   : a solution exists and was enumerated
//   overflow   : more free variables than MAX_FREE
//   min_weight : popcount of the best solution
//   solution   : best assignment in the variable layout of RREF
module gf2_min_weight_solve
  import gf2_pkg::*;
#(
  parameter int unsigned MAX_ROWS   = 4,
  parameter int unsigned MAX_COLS   = 5,
  parameter int unsigned MAX_FREE   = 8,
  parameter int unsigned MAX_ROWS_W = cnt_w(MAX_ROWS),
  parameter int unsigned MAX_COLS_W = cnt_w(MAX_COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MAX_ROWS_W-1:0] rows,
  input  logic [MAX_COLS_W-1:0] cols,
  input  logic                  start,
  input  logic [MAX_COLS-1:0]   RREF [MAX_ROWS],
  output logic                  ready,
  output logic                  solvable,
  output logic                  overflow,
  output logic [MAX_COLS_W-1:0] min_weight,
  output logic [MAX_COLS-1:0]   solution
);

  localparam int unsigned IW     = idx_w(MAX_COLS);
  localparam int unsigned FW     = cnt_w(MAX_FREE);
  localparam int unsigned MW     = MAX_FREE + 1;
  localparam int unsigned FREE_N = (MAX_FREE == 0) ? 1 : MAX_FREE;

  solve_state_t r_state, w_state_next;

  logic [MAX_COLS-1:0]   r_rref [MAX_ROWS];
  logic [MAX_ROWS_W-1:0] r_rows, r_row;
  logic [MAX_COLS_W-1:0] r_cols, r_col;
  logic [MAX_ROWS-1:0]   r_piv_valid;
  logic [IW-1:0]         r_piv_idx [MAX_ROWS];
  logic [MAX_COLS-1:0]   r_piv_cols;
  logic [IW-1:0]         r_free [FREE_N];
  logic [FW-1:0]         r_nfree;
  logic                  r_incons, r_ovf;
  logic [MW-1:0]         r_mask;
  logic [MAX_COLS_W-1:0] r_best_w;
  logic [MAX_COLS-1:0]   r_best_sol;
  logic                  r_ready, r_solvable, r_overflow;
  logic [MAX_COLS_W-1:0] r_min_weight;
  logic [MAX_COLS-1:0]   r_solution;

  logic [MAX_COLS_W-1:0] w_nvars;
  logic [MAX_COLS-1:0]   w_var_mask, w_rhs_mask;
  logic [MAX_COLS-1:0]   w_cur_row, w_lead_in, w_lead_onehot;
  logic [IW-1:0]         w_lead_idx;
  logic                  w_lead_valid, w_cur_rhs;
  logic [MAX_COLS-1:0]   w_col_bit;
  logic [IW-1:0]         w_col_pos;
  logic                  w_col_free, w_last_row, w_last_col, w_ovf_next;
  logic [MW-1:0]         w_last_mask;
  logic [MAX_COLS-1:0]   w_assign, w_sol;
  logic [MAX_COLS_W-1:0] w_pop;

  assign w_nvars = (r_cols == '0) ? '0 : r_cols - MAX_COLS_W'(1);

  // Field masks from the captured column count.
  always_comb begin
    w_var_mask = '0;
    w_rhs_mask = '0;
    for (int b = 0; b < int'(MAX_COLS); b++) begin
      w_var_mask[b] = (b + int'(r_cols)) > int'(MAX_COLS);
      w_rhs_mask[b] = (b + int'(r_cols)) == int'(MAX_COLS);
    end
  end

  always_comb begin
    w_cur_row = '0;
    for (int r = 0; r < int'(MAX_ROWS); r++) begin
      if (r_row == MAX_ROWS_W'(r)) w_cur_row = r_rref[r];
    end
  end

  assign w_lead_in = w_cur_row & w_var_mask;
  assign w_cur_rhs = |(w_cur_row & w_rhs_mask);

  gf2_leading_one #(
    .W (MAX_COLS),
    .IW(IW)
  ) u_lead (
    .i_vec  (w_lead_in),
    .o_idx  (w_lead_idx),
    .o_valid(w_lead_valid)
  );

  always_comb begin
    w_lead_onehot = '0;
    w_col_bit     = '0;
    w_col_pos     = '0;
    for (int b = 0; b < int'(MAX_COLS); b++) begin
      if (w_lead_valid && w_lead_idx == IW'(b)) w_lead_onehot[b] = 1'b1;
      if (b + int'(r_col) == int'(MAX_COLS) - 1) begin
        w_col_bit[b] = 1'b1;
        w_col_pos    = IW'(b);
      end
    end
  end

  assign w_col_free  = ~|(w_col_bit & r_piv_cols);
  assign w_last_row  = (r_row == r_rows - MAX_ROWS_W'(1));
  assign w_last_col  = (r_col == w_nvars - MAX_COLS_W'(1));
  assign w_ovf_next  = r_ovf | (w_col_free && r_nfree == FW'(MAX_FREE));
  assign w_last_mask = MW'((64'd1 << r_nfree) - 64'd1);

  // Candidate for the current mask: free bits straight from the mask, each
  // pivot bit back-substituted from its row.
  always_comb begin
    w_assign = '0;
    for (int i = 0; i < int'(FREE_N); i++) begin
      for (int b = 0; b < int'(MAX_COLS); b++) begin
        if (FW'(i) < r_nfree && r_mask[i] && r_free[i] == IW'(b)) w_assign[b] = 1'b1;
      end
    end
    w_sol = w_assign;
    for (int r = 0; r < int'(MAX_ROWS); r++) begin
      for (int b = 0; b < int'(MAX_COLS); b++) begin
        if (r_piv_valid[r] && r_piv_idx[r] == IW'(b)) begin
          w_sol[b] = (|(r_rref[r] & w_rhs_mask)) ^ (^(r_rref[r] & w_var_mask & w_assign));
        end
      end
    end
    w_pop = '0;
    for (int b = 0; b < int'(MAX_COLS); b++) w_pop = w_pop + MAX_COLS_W'(w_sol[b]);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (rows != '0)                    w_state_next = SCAN;
          else if (cols > MAX_COLS_W'(1))    w_state_next = COLLECT;
          else                               w_state_next = ENUM;
        end
      end
      SCAN: begin
        if (!w_lead_valid && w_cur_rhs)      w_state_next = DONE;
        else if (w_last_row)                 w_state_next = (w_nvars != '0) ? COLLECT : ENUM;
      end
      COLLECT: begin
        if (w_last_col)                      w_state_next = w_ovf_next ? DONE : ENUM;
      end
      ENUM: begin
        if (r_mask == w_last_mask)           w_state_next = DONE;
      end
      DONE:                                  w_state_next = IDLE;
      default:                               w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rows       <= '0;
      r_row        <= '0;
      r_cols       <= '0;
      r_col        <= '0;
      r_piv_valid  <= '0;
      r_piv_cols   <= '0;
      r_nfree      <= '0;
      r_incons     <= 1'b0;
      r_ovf        <= 1'b0;
      r_mask       <= '0;
      r_best_w     <= '1;
      r_best_sol   <= '0;
      r_ready      <= 1'b0;
      r_solvable   <= 1'b0;
      r_overflow   <= 1'b0;
      r_min_weight <= '0;
      r_solution   <= '0;
      for (int r = 0; r < int'(MAX_ROWS); r++) begin
        r_rref[r]    <= '0;
        r_piv_idx[r] <= '0;
      end
      for (int i = 0; i < int'(FREE_N); i++) r_free[i] <= '0;
    end else begin
      r_state <= w_state_next;
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            for (int r = 0; r < int'(MAX_ROWS); r++) r_rref[r] <= RREF[r];
            r_rows      <= rows;
            r_cols      <= cols;
            r_row       <= '0;
            r_col       <= '0;
            r_piv_valid <= '0;
            r_piv_cols  <= '0;
            r_nfree     <= '0;
            r_incons    <= 1'b0;
            r_ovf       <= 1'b0;
            r_mask      <= '0;
            r_best_w    <= '1;
            r_best_sol  <= '0;
          end
        end
        SCAN: begin
          r_row <= r_row + MAX_ROWS_W'(1);
          if (w_lead_valid) begin
            r_piv_cols <= r_piv_cols | w_lead_onehot;
            for (int r = 0; r < int'(MAX_ROWS); r++) begin
              if (r_row == MAX_ROWS_W'(r)) begin
                r_piv_valid[r] <= 1'b1;
                r_piv_idx[r]   <= w_lead_idx;
              end
            end
          end else if (w_cur_rhs) begin
            r_incons <= 1'b1;
          end
        end
        COLLECT: begin
          r_col <= r_col + MAX_COLS_W'(1);
          if (w_col_free) begin
            if (r_nfree == FW'(MAX_FREE)) begin
              r_ovf <= 1'b1;
            end else begin
              for (int i = 0; i < int'(FREE_N); i++) begin
                if (r_nfree == FW'(i)) r_free[i] <= w_col_pos;
              end
              r_nfree <= r_nfree + FW'(1);
            end
          end
        end
        ENUM: begin
          r_mask <= r_mask + MW'(1);
          // Strict compare: ties keep the earlier mask.
          if (w_pop < r_best_w) begin
            r_best_w   <= w_pop;
            r_best_sol <= w_sol;
          end
        end
        DONE: begin
          r_ready    <= 1'b1;
          r_solvable <= !r_incons && !r_ovf;
          r_overflow <= r_ovf;
          if (!r_incons && !r_ovf) begin
            r_min_weight <= r_best_w;
            r_solution   <= r_best_sol;
          end else begin
            r_min_weight <= '0;
            r_solution   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready      = r_ready;
  assign solvable   = r_solvable;
  assign overflow   = r_overflow;
  assign min_weight = r_min_weight;
  assign solution   = r_solution;

endmodule
